// File: rtl/am_pwm_modulator_pkg.sv
// Shared constants, state encoding and sizing helper for the AM PWM modulator.
package am_pwm_modulator_pkg;

  localparam int unsigned AM_PWM_STEPS         = 255;
  localparam int unsigned AM_CLKS_IN_PWM_STEPS = 1;
  localparam logic [7:0]  MIDSCALE             = 8'd128;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/am_pwm_modulator_if.sv
// Sample handshake from the decoder into the PWM modulator.
interface am_pwm_modulator_if;

  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);

endinterface

// File: rtl/am_pwm_modulator_sync_fifo.sv
// Show-ahead synchronous FIFO; extra pointer bit separates full from empty.
module am_pwm_modulator_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Lw = Aw + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == Lw'(Depth));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/am_pwm_modulator.sv
// Buffers decoder samples and emits a PWM whose duty follows each sample in turn.
module am_pwm_modulator
  import am_pwm_modulator_pkg::*;
#(
  parameter int unsigned PwmSteps      = AM_PWM_STEPS,
  parameter int unsigned ClksPerStep   = AM_CLKS_IN_PWM_STEPS,
  parameter int unsigned PeriodsPerSmp = 4,
  parameter int unsigned FifoDepth     = 16,
  parameter logic [7:0]  Midscale      = MIDSCALE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  am_pwm_modulator_if.slave           smp,
  output logic                        pwm_o,
  output logic                        underrun_o,
  output logic [$clog2(FifoDepth):0]  fifo_level_o
);

  localparam int unsigned PreW = cnt_width(ClksPerStep);
  localparam int unsigned PerW = cnt_width(PeriodsPerSmp);
  localparam logic [PreW-1:0] PreLast  = PreW'(ClksPerStep - 1);
  localparam logic [7:0]      StepLast = 8'(PwmSteps - 1);
  localparam logic [PerW-1:0] PerLast  = PerW'(PeriodsPerSmp - 1);

  state_e          state_q;
  logic [PreW-1:0] pre_cnt_q;
  logic [7:0]      step_cnt_q;
  logic [PerW-1:0] per_cnt_q;
  logic [7:0]      duty_q, duty_d;
  logic            pwm_q, underrun_q;

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       push, pop, run, boundary;

  always_comb begin
    run      = (state_q == StRun) && en_i;
    boundary = run && (pre_cnt_q == '0) && (step_cnt_q == '0) && (per_cnt_q == '0);
    push     = smp.sample_valid && !fifo_full;
    pop      = boundary && !fifo_empty;
    duty_d   = duty_q;
    if (boundary) begin
      duty_d = fifo_empty ? Midscale : fifo_head;
    end
  end

  assign smp.sample_ready = !fifo_full;
  assign pwm_o            = pwm_q;
  assign underrun_o       = underrun_q;

  am_pwm_modulator_sync_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (smp.sample_in),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pre_cnt_q  <= '0;
      step_cnt_q <= '0;
      per_cnt_q  <= '0;
      duty_q     <= Midscale;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      underrun_q <= boundary && fifo_empty;
      if (!en_i) begin
        state_q    <= StIdle;
        pre_cnt_q  <= '0;
        step_cnt_q <= '0;
        per_cnt_q  <= '0;
        pwm_q      <= 1'b0;
      end else if (state_q == StIdle) begin
        // Counters are already zero, so the next cycle is a sample boundary.
        state_q <= StRun;
        pwm_q   <= 1'b0;
      end else begin
        pwm_q <= (step_cnt_q < duty_d);
        if (pre_cnt_q == PreLast) begin
          pre_cnt_q <= '0;
          if (step_cnt_q == StepLast) begin
            step_cnt_q <= '0;
            per_cnt_q  <= (per_cnt_q == PerLast) ? '0 : per_cnt_q + 1'b1;
          end else begin
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end else begin
          pre_cnt_q <= pre_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_am_pwm_modulator.sv
// Directed bench for am_pwm_modulator with a cycle-level reference model.
module tb_am_pwm_modulator;

  localparam int Steps   = 255;
  localparam int Clks    = 1;
  localparam int Periods = 1;
  localparam int Depth   = 16;
  localparam int Mid     = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       pwm, und;
  logic [4:0] level;

  am_pwm_modulator_if smp_if ();

  am_pwm_modulator #(
    .PwmSteps      (Steps),
    .ClksPerStep   (Clks),
    .PeriodsPerSmp (Periods),
    .FifoDepth     (Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .smp          (smp_if.slave),
    .pwm_o        (pwm),
    .underrun_o   (und),
    .fifo_level_o (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of samples plus elapsed run time.
  int   mq[$];
  bit   m_run = 0;
  int   m_t = 0;
  int   m_duty = Mid;
  int   e_pwm = 0, e_und = 0, e_level = 0, e_ready = 1;
  bit   check_en = 0;

  always @(posedge clk) begin
    bit pushed, bnd;
    if (rst) begin
      mq.delete();
      m_run = 0; m_t = 0; m_duty = Mid; e_pwm = 0; e_und = 0;
    end else begin
      pushed = smp_if.sample_valid && (mq.size() < Depth);
      bnd    = m_run && en && (m_t % (Steps * Clks * Periods) == 0);
      e_und  = (bnd && mq.size() == 0) ? 1 : 0;
      if (bnd) m_duty = (mq.size() == 0) ? Mid : mq.pop_front();
      if (!en) begin
        m_run = 0; m_t = 0; e_pwm = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0; e_pwm = 0;
      end else begin
        e_pwm = (((m_t / Clks) % Steps) < m_duty) ? 1 : 0;
        m_t++;
      end
      if (pushed) mq.push_back(int'(smp_if.sample_in));
    end
    e_level = mq.size();
    e_ready = (mq.size() < Depth) ? 1 : 0;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pwm", int'(pwm), e_pwm);
      chk("underrun", int'(und), e_und);
      chk("level", int'(level), e_level);
      chk("ready", int'(smp_if.sample_ready), e_ready);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(input int n, output int highs, output int unds);
    highs = 0;
    unds  = 0;
    repeat (n) begin
      @(negedge clk);
      highs += int'(pwm);
      unds  += int'(und);
    end
  endtask

  initial begin
    int h, u;
    logic [7:0] v;
    smp_if.sample_in    = 8'h00;
    smp_if.sample_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    check_en = 1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ready", int'(smp_if.sample_ready), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_underrun", int'(und), 0);

    // 0x40 sample: 64 high, 191 low
    smp_if.sample_in = 8'h40; smp_if.sample_valid = 1'b1;
    tick(1);
    smp_if.sample_valid = 1'b0;
    chk("lvl_after_push", int'(level), 1);
    en = 1'b1;
    tick(1);
    measure(255, h, u);
    chk("duty40_high", h, 64);
    chk("duty40_level", int'(level), 0);

    // Empty FIFO: midscale carrier with an underrun each period
    measure(510, h, u);
    chk("empty_high", h, 256);
    chk("empty_underruns", u, 2);

    // Push lands on a boundary with empty FIFO: no bypass
    smp_if.sample_in = 8'h00; smp_if.sample_valid = 1'b1;
    tick(1);
    chk("nobypass_und", int'(und), 1);
    chk("nobypass_lvl", int'(level), 1);
    smp_if.sample_in = 8'hFF;
    tick(1);
    smp_if.sample_valid = 1'b0;
    chk("two_queued", int'(level), 2);
    measure(253, h, u);
    measure(255, h, u);
    chk("duty00_high", h, 0);
    measure(255, h, u);
    chk("dutyFF_high", h, 255);

    en = 1'b0;
    tick(1);
    chk("en_fall_pwm", int'(pwm), 0);

    // Fill while idle; 17th push must be dropped
    for (int i = 0; i < 17; i++) begin
      v = (i == 16) ? 8'hEE : 8'(i * 16 + 3);
      smp_if.sample_in = v; smp_if.sample_valid = 1'b1;
      tick(1);
      if (i == 15) begin
        chk("full_ready", int'(smp_if.sample_ready), 0);
        chk("full_level", int'(level), 16);
      end
    end
    smp_if.sample_valid = 1'b0;
    chk("overflow_level", int'(level), 16);
    en = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) begin
      measure(255, h, u);
      chk("order_high", h, i * 16 + 3);
      if (i == 0) begin
        chk("ready_after_pop", int'(smp_if.sample_ready), 1);
        chk("level_after_pop", int'(level), 15);
      end
    end

    // Mid-period reset with five samples queued
    for (int i = 0; i < 5; i++) begin
      smp_if.sample_in = 8'(i + 1); smp_if.sample_valid = 1'b1;
      tick(1);
    end
    smp_if.sample_valid = 1'b0;
    tick(7);
    chk("pre_rst_level", int'(level), 5);
    rst = 1'b1;
    tick(1);
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_ready", int'(smp_if.sample_ready), 1);
    chk("midrst_und", int'(und), 0);
    rst = 1'b0;
    measure(300, h, u);
    en = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
